// File: rtl/rgb_line_driver_multi.sv
// Multi-lane threshold-PWM row shifter for HUB75-style panels.
// Shifts one pass per PWM level, latches it, and overlaps display with the next shift.
module rgb_line_driver_multi #(
    parameter int COLS       = 32,
    parameter int BITS       = 8,
    parameter int CHANNELS   = 6,
    parameter int LAT_CYCLES = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            line_start,
    input  logic [CHANNELS*COLS*BITS-1:0]   data,
    output logic                            clk_o,
    output logic [CHANNELS-1:0]             line_o,
    output logic                            line_lat,
    output logic                            line_oe,
    output logic                            line_rdy,
    output logic                            overrun
);
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNTW = $clog2(2*COLS + LAT_CYCLES);
    localparam logic [CLW-1:0]  COL_LAST = CLW'(COLS - 1);
    localparam logic [CNTW-1:0] LAT_LAST = CNTW'(LAT_CYCLES - 1);
    localparam logic [CNTW-1:0] DRN_LAST = CNTW'(2*COLS - 1);
    localparam logic [BITS-1:0] PWM_LAST = BITS'((2**BITS) - 2);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [CHANNELS*COLS*BITS-1:0]   shadow_q, shadow_d;
    logic [BITS-1:0]                 pwm_q, pwm_d;
    logic [CLW-1:0]                  col_q, col_d;
    logic [CNTW-1:0]                 cnt_q, cnt_d;
    logic                            phase_q, phase_d;
    logic                            first_q, first_d;

    logic                            clk_o_q, lat_q, oe_q, rdy_q, ovr_q;
    logic                            clk_o_d, lat_d, oe_d, rdy_d, ovr_d;
    logic [CHANNELS-1:0]             lane_q, lane_d;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pwm_d    = pwm_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        first_d  = first_q;
        ovr_d    = line_start && (state_q != IDLE);
        unique case (state_q)
            IDLE: if (line_start) begin
                shadow_d = data;
                pwm_d    = '0;
                col_d    = '0;
                phase_d  = 1'b0;
                first_d  = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        cnt_d   = '0;
                        state_d = LATCH;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            LATCH: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    first_d = 1'b0;
                    if (pwm_q < PWM_LAST) begin
                        pwm_d   = pwm_q + 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRN_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort keeps the shadow; everything else returns to its idle value.
        if (!enable) begin
            state_d = IDLE;
            pwm_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            phase_d = 1'b0;
            first_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Pin values are decoded from the state being entered, so they register alongside it.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        logic [BITS-1:0] pix;
        assign pix        = shadow_d[(ch*COLS + int'(col_d))*BITS +: BITS];
        assign lane_d[ch] = (state_d == SHIFT) && (pix > pwm_d);
    end

    always_comb begin
        clk_o_d = (state_d == SHIFT) && phase_d;
        lat_d   = (state_d == LATCH);
        rdy_d   = (state_d == IDLE);
        oe_d    = 1'b1;
        if (state_d == SHIFT) oe_d = first_d;
        if (state_d == DRAIN) oe_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            pwm_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            first_q  <= 1'b0;
            clk_o_q  <= 1'b0;
            lane_q   <= '0;
            lat_q    <= 1'b0;
            oe_q     <= 1'b1;
            rdy_q    <= 1'b1;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            first_q  <= first_d;
            clk_o_q  <= clk_o_d;
            lane_q   <= lane_d;
            lat_q    <= lat_d;
            oe_q     <= oe_d;
            rdy_q    <= rdy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign clk_o    = clk_o_q;
    assign line_o   = lane_q;
    assign line_lat = lat_q;
    assign line_oe  = oe_q;
    assign line_rdy = rdy_q;
    assign overrun  = ovr_q;
endmodule

// File: tb/tb_rgb_line_driver_multi.sv
// Randomized bench for rgb_line_driver_multi against a cycle-timeline model of one line.
module tb_rgb_line_driver_multi;
    localparam int COLS = 4;
    localparam int BITS = 2;
    localparam int CH   = 2;
    localparam int LAT  = 1;
    localparam int PER  = 2*COLS + LAT;
    localparam int NP   = (1 << BITS) - 1;
    localparam int LEN  = NP*PER + 2*COLS;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, line_start = 1'b0;
    logic [CH*COLS*BITS-1:0] data = '0;
    logic clk_o, line_lat, line_oe, line_rdy, overrun;
    logic [CH-1:0] line_o;

    int n_tests = 0, n_fail = 0;
    int pix[CH][COLS];

    always #5 clk = ~clk;

    rgb_line_driver_multi #(.COLS(COLS), .BITS(BITS), .CHANNELS(CH), .LAT_CYCLES(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .line_start(line_start), .data(data),
        .clk_o(clk_o), .line_o(line_o), .line_lat(line_lat), .line_oe(line_oe),
        .line_rdy(line_rdy), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({overrun, line_rdy, line_oe, line_lat, clk_o, line_o});
    endfunction

    // t = cycles since the start sample; pass p covers [p*PER, (p+1)*PER).
    function automatic logic [31:0] model(input int t, input bit ov);
        logic [CH-1:0] lo = '0;
        bit ck = 1'b0, lat = 1'b0, oe = 1'b1, rdy = 1'b0;
        if (t >= LEN) rdy = 1'b1;
        else if (t >= NP*PER) oe = 1'b0;
        else begin
            int p = t / PER;
            int r = t % PER;
            if (r < 2*COLS) begin
                ck = bit'(r % 2);
                oe = (p == 0);
                for (int c = 0; c < CH; c++) lo[c] = (pix[c][r/2] > p);
            end else begin
                lat = 1'b1;
            end
        end
        return 32'({ov, rdy, oe, lat, ck, lo});
    endfunction

    task automatic load_data();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < COLS; k++)
                data[(c*COLS + k)*BITS +: BITS] = BITS'(pix[c][k]);
    endtask

    task automatic rand_pix();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < COLS; k++)
                pix[c][k] = int'($urandom_range(0, NP));
    endtask

    // One full line; drop_at >= 0 lowers enable at that sample instead of finishing.
    task automatic run_line(input int drop_at, input bit force_last);
        bit st_prev = 1'b0;
        @(negedge clk);
        load_data();
        enable = 1'b1;
        line_start = 1'b1;
        for (int j = 0; j <= LEN + 1; j++) begin
            @(negedge clk);
            if (drop_at >= 0 && j == drop_at + 1) begin
                chk("abort", obs(), model(LEN, 1'b0));
                line_start = 1'b1;
                @(negedge clk);
                chk("start_while_disabled", obs(), model(LEN, 1'b0));
                line_start = 1'b0;
                return;
            end
            chk("line", obs(), model(j, st_prev && (j - 1) < LEN));
            if (j == 0) data = ($urandom_range(0, 1) == 0) ? '0 : CH*COLS*BITS'($urandom);
            line_start = (j >= 1 && j < LEN) &&
                         (($urandom_range(0, 7) == 0) || (force_last && j == LEN - 1));
            if (j == drop_at) begin
                enable = 1'b0;
                line_start = 1'b0;
            end
            st_prev = line_start;
        end
        line_start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset", obs(), model(LEN, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", obs(), model(LEN, 1'b0));

        pix[0][0] = 3; pix[0][1] = 1; pix[0][2] = 0; pix[0][3] = 2;
        for (int k = 0; k < COLS; k++) pix[1][k] = NP - k % (NP + 1);
        run_line(-1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rand_pix();
            run_line(-1, bit'(i % 2));
        end

        rand_pix();
        run_line(PER + 2*COLS, 1'b0);
        rand_pix();
        run_line(-1, 1'b0);

        rand_pix();
        @(negedge clk);
        load_data();
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", obs(), model(LEN, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_release", obs(), model(LEN, 1'b0));
        end

        rand_pix();
        run_line(-1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
